exec_trace_buffer: RTL and testbench

//  Synthesizable execution-trace capture for the single-cycle datapath. Replaces per-signal
//  $monitor printing. Records {PC, instruction, result, RegWrite} per retired instruction

---
 rtl/exec_trace_buffer_if.sv | 41 ++++
 rtl/exec_trace_buffer.sv | 122 ++++++++++++
 tb/tb_exec_trace_buffer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/exec_trace_buffer_if.sv
// Bundle of capture, trigger and read-back signals for exec_trace_buffer.
// The master side (bench or debug port) drives capture/control; the slave side is the buffer.
interface exec_trace_buffer_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16
);
  localparam int AW = $clog2(DEPTH);

  logic               cap_valid;
  logic [PC_W-1:0]    cap_pc;
  logic [INSTR_W-1:0] cap_instr;
  logic [DATA_W-1:0]  cap_result;
  logic               cap_regwrite;
  logic               arm;
  logic               trig_pc_en;
  logic [PC_W-1:0]    trig_pc;
  logic               trig_force;
  logic               rd_en;
  logic [AW-1:0]      rd_idx;
  logic               rd_valid;
  logic [PC_W-1:0]    rd_pc;
  logic [INSTR_W-1:0] rd_instr;
  logic [DATA_W-1:0]  rd_result;
  logic               rd_regwrite;
  logic [1:0]         state;
  logic [AW:0]        count;

  modport master (
    output cap_valid, cap_pc, cap_instr, cap_result, cap_regwrite,
    output arm, trig_pc_en, trig_pc, trig_force, rd_en, rd_idx,
    input  rd_valid, rd_pc, rd_instr, rd_result, rd_regwrite, state, count
  );

  modport slave (
    input  cap_valid, cap_pc, cap_instr, cap_result, cap_regwrite,
    input  arm, trig_pc_en, trig_pc, trig_force, rd_en, rd_idx,
    output rd_valid, rd_pc, rd_instr, rd_result, rd_regwrite, state, count
  );
endinterface

// File: rtl/exec_trace_buffer.sv
// Circular execution-trace capture with PC-match / forced trigger and post-trigger freeze.
// state | meaning: IDLE no capture | ARMED capturing, waiting for trigger | POST post-trigger fill | DONE frozen
module exec_trace_buffer #(
  parameter int PC_W      = 32,
  parameter int INSTR_W   = 32,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8
) (
  input logic                  clock_i,
  input logic                  reset_i,
  exec_trace_buffer_if.slave   bus_if
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = PC_W + INSTR_W + DATA_W + 1;
  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_POST  = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] post_cnt_q, post_cnt_d;
  logic [AW:0]   count_q, count_d;
  logic          wr_en;
  logic          trig;

  logic [EW-1:0] mem [DEPTH];

  logic          rd_ok;
  logic [AW-1:0] rd_phys;
  logic          rd_valid_q;
  logic [EW-1:0] rd_data_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      post_cnt_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      post_cnt_q <= post_cnt_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    post_cnt_d = post_cnt_q;
    count_d    = count_q;
    wr_en      = 1'b0;
    trig       = bus_if.trig_force |
                 (bus_if.cap_valid & bus_if.trig_pc_en & (bus_if.cap_pc == bus_if.trig_pc));

    case (state_q)
      // arm outranks trig_force here: trig_force has no effect outside ARMED
      S_IDLE, S_DONE: begin
        if (bus_if.arm) begin
          state_d  = S_ARMED;
          wr_ptr_d = '0;
          count_d  = '0;
        end
      end
      S_ARMED: begin
        wr_en = bus_if.cap_valid;
        if (trig) begin
          if (POST_TRIG == 0) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_POST;
            post_cnt_d = AW'(POST_TRIG);
          end
        end
      end
      S_POST: begin
        wr_en = bus_if.cap_valid;
        if (bus_if.cap_valid) begin
          post_cnt_d = post_cnt_q - AW'(1);
          if (post_cnt_q == AW'(1)) state_d = S_DONE;
        end
      end
      default: ;
    endcase

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (count_q != CNT_MAX) count_d = count_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (wr_en)
      mem[wr_ptr_q] <= {bus_if.cap_pc, bus_if.cap_instr, bus_if.cap_result, bus_if.cap_regwrite};
  end

  // Once the buffer has wrapped, the oldest entry sits at the write pointer.
  assign rd_phys = ((count_q == CNT_MAX) ? wr_ptr_q : '0) + bus_if.rd_idx;
  assign rd_ok   = bus_if.rd_en & ((state_q == S_IDLE) | (state_q == S_DONE)) &
                   ({1'b0, bus_if.rd_idx} < count_q);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_ok;
      rd_data_q  <= rd_ok ? mem[rd_phys] : '0;
    end
  end

  assign bus_if.rd_valid = rd_valid_q;
  assign {bus_if.rd_pc, bus_if.rd_instr, bus_if.rd_result, bus_if.rd_regwrite} = rd_data_q;
  assign bus_if.state    = state_q;
  assign bus_if.count    = count_q;
endmodule

// File: tb/tb_exec_trace_buffer.sv
// Scoreboard bench for exec_trace_buffer: two instances (POST_TRIG=3 and POST_TRIG=0), DEPTH=8.
module tb_exec_trace_buffer;
  logic clk = 1'b0;
  logic rst_x, rst_y;
  always #5 clk = ~clk;

  exec_trace_buffer_if #(.DEPTH(8)) ia ();
  exec_trace_buffer_if #(.DEPTH(8)) ib ();

  exec_trace_buffer #(.DEPTH(8), .POST_TRIG(3)) dut_a (.clock_i(clk), .reset_i(rst_x), .bus_if(ia));
  exec_trace_buffer #(.DEPTH(8), .POST_TRIG(0)) dut_b (.clock_i(clk), .reset_i(rst_y), .bus_if(ib));

  int n_chk  = 0;
  int n_fail = 0;
  logic [97:0] sb [$];
  logic fire_a = 1'b0, fire_b = 1'b0;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'hA000_0000 | pc;
  endfunction

  function automatic logic [97:0] exp_entry(input logic v, input logic [31:0] pc);
    if (!v) return '0;
    return {1'b1, pc, instr_of(pc), ~pc, pc[2]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ia.cap_valid = 0; ia.trig_force = 0; ia.arm = 0; ia.rd_en = 0;
    ib.cap_valid = 0; ib.trig_force = 0; ib.arm = 0; ib.rd_en = 0;
  endtask

  task automatic cyc(input bit sel, input logic v, input logic [31:0] pc,
                     input logic frc, input logic arm_);
    if (!sel) begin
      ia.cap_valid = v; ia.cap_pc = pc; ia.cap_instr = instr_of(pc);
      ia.cap_result = ~pc; ia.cap_regwrite = pc[2]; ia.trig_force = frc; ia.arm = arm_;
    end else begin
      ib.cap_valid = v; ib.cap_pc = pc; ib.cap_instr = instr_of(pc);
      ib.cap_result = ~pc; ib.cap_regwrite = pc[2]; ib.trig_force = frc; ib.arm = arm_;
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic rd(input bit sel, input logic [2:0] idx, input logic v, input logic [31:0] pc);
    sb.push_back(exp_entry(v, pc));
    if (!sel) begin ia.rd_en = 1; ia.rd_idx = idx; end
    else      begin ib.rd_en = 1; ib.rd_idx = idx; end
    @(negedge clk);
    idle_inputs();
  endtask

  // Monitor: compares each read response against the scoreboard head.
  always @(posedge clk) begin
    fire_a <= ia.rd_en;
    fire_b <= ib.rd_en;
  end

  always @(negedge clk) begin
    logic [97:0] got, e;
    if (fire_a || fire_b) begin
      got = fire_a ? {ia.rd_valid, ia.rd_pc, ia.rd_instr, ia.rd_result, ia.rd_regwrite}
                   : {ib.rd_valid, ib.rd_pc, ib.rd_instr, ib.rd_result, ib.rd_regwrite};
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: got %0h with empty scoreboard", got);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL rd_data: got v=%0b pc=%0h instr=%0h res=%0h rw=%0b expected v=%0b pc=%0h instr=%0h res=%0h rw=%0b",
                   got[97], got[96:65], got[64:33], got[32:1], got[0],
                   e[97], e[96:65], e[64:33], e[32:1], e[0]);
        end
      end
    end
    if ((!fire_a && ia.rd_valid === 1'b1) || (!fire_b && ib.rd_valid === 1'b1)) begin
      n_chk++;
      n_fail++;
      $display("FAIL rd_valid_pulse: got 1 expected 0 without a read request");
    end
  end

  initial begin
    rst_x = 1; rst_y = 1;
    idle_inputs();
    ia.cap_pc = 0; ia.cap_instr = 0; ia.cap_result = 0; ia.cap_regwrite = 0;
    ia.trig_pc_en = 0; ia.trig_pc = 0; ia.rd_idx = 0;
    ib.cap_pc = 0; ib.cap_instr = 0; ib.cap_result = 0; ib.cap_regwrite = 0;
    ib.trig_pc_en = 0; ib.trig_pc = 0; ib.rd_idx = 0;
    repeat (2) @(negedge clk);
    rst_x = 0; rst_y = 0;

    // Reset state
    chk("reset_state_a", 32'(ia.state), 32'd0);
    chk("reset_count_a", 32'(ia.count), 32'd0);
    chk("reset_state_b", 32'(ib.state), 32'd0);
    rd(0, 3'd0, 1'b0, 32'h0);

    // No-wrap capture with forced trigger (POST_TRIG=0 instance)
    cyc(1, 0, 0, 0, 1);
    chk("b_armed", 32'(ib.state), 32'd1);
    for (int i = 0; i < 5; i++) cyc(1, 1, 32'(4*i), 0, 0);
    chk("b_count5", 32'(ib.count), 32'd5);
    rd(1, 3'd0, 1'b0, 32'h0);
    cyc(1, 0, 0, 1, 0);
    chk("b_done", 32'(ib.state), 32'd3);
    chk("b_done_count", 32'(ib.count), 32'd5);
    for (int i = 0; i < 5; i++) rd(1, 3'(i), 1'b1, 32'(4*i));
    rd(1, 3'd5, 1'b0, 32'h0);

    // PC trigger with wrap
    ia.trig_pc_en = 1; ia.trig_pc = 32'h40;
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 32'(4*i), 0, 0);
      if (i == 16) chk("a_post_after_trig", 32'(ia.state), 32'd2);
    end
    chk("a_done", 32'(ia.state), 32'd3);
    chk("a_count8", 32'(ia.count), 32'd8);
    cyc(0, 1, 32'h50, 0, 0);
    chk("a_frozen_count", 32'(ia.count), 32'd8);
    for (int i = 0; i < 8; i++) rd(0, 3'(i), 1'b1, 32'h30 + 32'(4*i));
    ia.trig_pc_en = 0;

    // Arm from DONE, arm ignored while ARMED, gaps in POST
    cyc(0, 0, 0, 0, 1);
    chk("a_rearm_state", 32'(ia.state), 32'd1);
    chk("a_rearm_count", 32'(ia.count), 32'd0);
    cyc(0, 1, 32'h100, 0, 0);
    cyc(0, 1, 32'h104, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("a_arm_ignored_state", 32'(ia.state), 32'd1);
    chk("a_arm_ignored_count", 32'(ia.count), 32'd2);
    cyc(0, 1, 32'h108, 0, 0);
    cyc(0, 1, 32'h10C, 1, 0);
    chk("a_force_post", 32'(ia.state), 32'd2);
    chk("a_force_count", 32'(ia.count), 32'd4);
    cyc(0, 0, 0, 1, 0);
    chk("a_post_idle_force", 32'(ia.state), 32'd2);
    cyc(0, 1, 32'h110, 0, 0);
    chk("a_post_1", 32'(ia.state), 32'd2);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 32'h114, 0, 0);
    chk("a_post_2", 32'(ia.state), 32'd2);
    cyc(0, 0, 0, 0, 0);
    chk("a_post_gap", 32'(ia.state), 32'd2);
    cyc(0, 1, 32'h118, 0, 0);
    chk("a_post_done", 32'(ia.state), 32'd3);
    chk("a_post_count", 32'(ia.count), 32'd7);
    for (int i = 0; i < 7; i++) rd(0, 3'(i), 1'b1, 32'h100 + 32'(4*i));
    rd(0, 3'd7, 1'b0, 32'h0);

    // POST_TRIG=0 PC trigger, then arm beats trig_force in DONE
    ib.trig_pc_en = 1; ib.trig_pc = 32'h8;
    cyc(1, 0, 0, 0, 1);
    cyc(1, 1, 32'h0, 0, 0);
    cyc(1, 1, 32'h4, 0, 0);
    chk("b_pc_armed", 32'(ib.state), 32'd1);
    cyc(1, 1, 32'h8, 0, 0);
    chk("b_pc_done", 32'(ib.state), 32'd3);
    chk("b_pc_count", 32'(ib.count), 32'd3);
    rd(1, 3'd2, 1'b1, 32'h8);
    cyc(1, 0, 0, 1, 1);
    chk("b_arm_priority", 32'(ib.state), 32'd1);
    chk("b_arm_priority_cnt", 32'(ib.count), 32'd0);

    // Async reset in the middle of POST
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 32'h200, 1, 0);
    chk("a_pre_reset_state", 32'(ia.state), 32'd2);
    #2 rst_x = 1;
    #1;
    chk("a_async_state", 32'(ia.state), 32'd0);
    chk("a_async_count", 32'(ia.count), 32'd0);
    @(negedge clk);
    rst_x = 0;
    rd(0, 3'd0, 1'b0, 32'h0);

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
